// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared defaults and helpers for the dff_pipe register pipeline.
package dff_pipe_pkg;

  localparam int DFF_PIPE_WIDTH_DEF  = 8;
  localparam int DFF_PIPE_STAGES_DEF = 3;

  // Width of a counter that must hold every value from 0 to stages.
  function automatic int cnt_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage: one valid+data register slot of the dff_pipe pipeline.
// The slot accepts from upstream whenever it is empty or its own word
// is leaving, which is what lets bubbles collapse.
// Optional feature: DFF_PIPE_DATA_RST_EN adds a reset to the data register.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = DFF_PIPE_WIDTH_DEF
`ifdef DFF_PIPE_DATA_RST_EN
  , parameter logic [WIDTH-1:0] RST_VAL = '0
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  assign ready = !valid_reg || down_ready;
  assign valid = valid_reg;
  assign data  = data_reg;

  // Valid flag: take the upstream valid whenever this slot can load; flush empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (ready) begin
      valid_reg <= up_valid;
    end
  end

`ifdef DFF_PIPE_DATA_RST_EN
  // Data word: capture only real upstream words so a held word is never overwritten by a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= RST_VAL;
    end else if (ready && up_valid) begin
      data_reg <= up_data;
    end
  end
`else
  // Data word: capture only real upstream words; no reset so it maps onto plain flops.
  always_ff @(posedge clk) begin
    if (ready && up_valid) begin
      data_reg <= up_data;
    end
  end
`endif

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: STAGES-deep retiming pipeline with valid/ready flow control.
// The ready chain runs combinationally from out_ready back to in_ready,
// so a full pipeline still moves one word per cycle when drained.
// Optional feature: DFF_PIPE_DATA_RST_EN resets data registers to RST_VAL.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = DFF_PIPE_WIDTH_DEF,
  parameter int               STAGES  = DFF_PIPE_STAGES_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [cnt_w(STAGES)-1:0]    count
);

  localparam int CW = cnt_w(STAGES);

  logic          push;
  logic          pop;
  logic [CW-1:0] count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             up_valid;
      logic [WIDTH-1:0] up_data;
      logic             down_ready;
      logic             rdy;
      logic             vld;
      logic [WIDTH-1:0] dat;

      if (gi == 0) begin : g_first
        assign up_valid = in_valid;
        assign up_data  = in_data;
      end else begin : g_next
        assign up_valid = g_stage[gi-1].vld;
        assign up_data  = g_stage[gi-1].dat;
      end

      if (gi == STAGES - 1) begin : g_last
        assign down_ready = out_ready;
      end else begin : g_mid
        assign down_ready = g_stage[gi+1].rdy;
      end

      dff_pipe_stage #(
        .WIDTH   (WIDTH)
`ifdef DFF_PIPE_DATA_RST_EN
        , .RST_VAL (RST_VAL)
`endif
      ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .down_ready (down_ready),
        .ready      (rdy),
        .valid      (vld),
        .data       (dat)
      );
    end
  endgenerate

  assign in_ready  = g_stage[0].rdy && !flush;
  assign out_valid = g_stage[STAGES-1].vld && !flush;
  assign out_data  = g_stage[STAGES-1].dat;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_reg;

  // Occupancy: words never vanish inside the pipe, so only handshakes change the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (flush) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: randomized + directed bench for dff_pipe. Two instances run
// side by side (STAGES=3/WIDTH=8 and STAGES=1/WIDTH=1) against a queue model
// in which each in-flight word carries its stage position.
module tb_dff_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       flush_s     [2];
  logic       in_valid_s  [2];
  logic       out_ready_s [2];
  logic [7:0] in_data_s   [2];

  logic       in_ready0, out_valid0;
  logic [7:0] out_data0;
  logic [1:0] count0;
  logic       in_ready1, out_valid1;
  logic [0:0] out_data1;
  logic [0:0] count1;
  logic [0:0] in_data1;

  assign in_data1 = in_data_s[1][0];

  dff_pipe #(.WIDTH(8), .STAGES(3), .RST_VAL(8'hA5)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_s[0]),
    .in_valid  (in_valid_s[0]),
    .in_ready  (in_ready0),
    .in_data   (in_data_s[0]),
    .out_valid (out_valid0),
    .out_ready (out_ready_s[0]),
    .out_data  (out_data0),
    .count     (count0)
  );

  dff_pipe #(.WIDTH(1), .STAGES(1), .RST_VAL(1'b0)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_s[1]),
    .in_valid  (in_valid_s[1]),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready_s[1]),
    .out_data  (out_data1),
    .count     (count1)
  );

  typedef struct {
    logic [7:0] data;
    int         pos;
  } ent_t;

  ent_t mq [2][$];
  logic exp_ir [2];
  logic exp_ov [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic       cap = 1'b0;
  logic [7:0] got0 [$];
  int         first_acc = -1;
  int         first_pop = -1;

  function automatic int stages_of(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic logic [7:0] mask_of(input int i);
    return (i == 0) ? 8'hFF : 8'h01;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Settle combinational outputs, then compare every DUT output against the model.
  task automatic settle();
    int ir, ov, od, cnt, sz, s;
    #1;
    for (int i = 0; i < 2; i++) begin
      s   = stages_of(i);
      sz  = mq[i].size();
      ir  = (i == 0) ? int'(in_ready0)  : int'(in_ready1);
      ov  = (i == 0) ? int'(out_valid0) : int'(out_valid1);
      od  = (i == 0) ? int'(out_data0)  : int'(out_data1);
      cnt = (i == 0) ? int'(count0)     : int'(count1);
      exp_ir[i] = !flush_s[i] && !(sz == s && !out_ready_s[i]);
      exp_ov[i] = !flush_s[i] && (sz > 0) && (mq[i][0].pos == s - 1);
      check($sformatf("in_ready%0d", i), ir, int'(exp_ir[i]));
      check($sformatf("out_valid%0d", i), ov, int'(exp_ov[i]));
      check($sformatf("count%0d", i), cnt, sz);
      if (exp_ov[i]) check($sformatf("out_data%0d", i), od, int'(mq[i][0].data));
    end
  endtask

  // Advance the model across one rising edge, then park at the falling edge.
  task automatic edge_update();
    ent_t e;
    int   s, lim;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      s = stages_of(i);
      if (!rst_n || flush_s[i]) begin
        mq[i].delete();
      end else begin
        if (exp_ov[i] && out_ready_s[i]) begin
          e = mq[i].pop_front();
          $display("xfer dut%0d edge=%0d data=%0h", i, cyc, e.data);
          if (i == 0 && cap) begin
            got0.push_back(e.data);
            if (got0.size() == 1) first_pop = cyc;
          end
        end
        for (int k = 0; k < mq[i].size(); k++) begin
          lim = (k == 0) ? s - 1 : mq[i][k-1].pos - 1;
          e = mq[i][k];
          e.pos = (e.pos + 1 > lim) ? lim : e.pos + 1;
          mq[i][k] = e;
        end
        if (in_valid_s[i] && exp_ir[i]) begin
          e.data = in_data_s[i] & mask_of(i);
          e.pos  = 0;
          mq[i].push_back(e);
          if (i == 0 && cap && first_acc < 0) first_acc = cyc;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    edge_update();
  endtask

  task automatic drive(input int i, input logic iv, input logic [7:0] d,
                       input logic ordy, input logic fl);
    in_valid_s[i]  = iv;
    in_data_s[i]   = d;
    out_ready_s[i] = ordy;
    flush_s[i]     = fl;
  endtask

  task automatic random_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 2; i++)
        drive(i, $urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
              $urandom_range(0, 39) == 0);
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) drive(i, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    settle();
    check("reset_in_ready", int'(in_ready0), 1);
    check("reset_count", int'(count0), 0);
    check("reset_out_valid", int'(out_valid0), 0);
    edge_update();

    // Continuous stream 0x01..0x10 with the sink always ready.
    cap = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      drive(0, 1'b1, 8'(k), 1'b1, 1'b0);
      settle();
      if (k == 8) check("stream_count", int'(count0), 3);
      edge_update();
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
      step();
    end
    cap = 1'b0;
    check("stream_words", got0.size(), 16);
    for (int k = 0; k < got0.size(); k++) check("stream_order", int'(got0[k]), k + 1);
    check("stream_latency", first_pop - first_acc, 3);

    // Fill, stall for 5 cycles, then release with push and pop together.
    for (int k = 1; k <= 3; k++) begin
      drive(0, 1'b1, 8'(k), 1'b0, 1'b0);
      step();
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 8'h04, 1'b0, 1'b0);
      settle();
      check("full_count", int'(count0), 3);
      check("full_in_ready", int'(in_ready0), 0);
      check("full_out_data", int'(out_data0), 8'h01);
      edge_update();
    end
    drive(0, 1'b1, 8'h04, 1'b1, 1'b0);
    settle();
    check("release_in_ready", int'(in_ready0), 1);
    edge_update();
    for (int k = 5; k <= 6; k++) begin
      drive(0, 1'b1, 8'(k), 1'b1, 1'b0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
      step();
    end

    // Bubbles with a stalled sink collapse into adjacent stages.
    drive(0, 1'b1, 8'h11, 1'b0, 1'b0); step();
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0); step();
    step();
    drive(0, 1'b1, 8'h22, 1'b0, 1'b0); step();
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    settle();
    check("bubble_count", int'(count0), 2);
    check("bubble_out_data", int'(out_data0), 8'h11);
    edge_update();
    settle();
    edge_update();

    // Flush with two words in flight and a word offered.
    drive(0, 1'b1, 8'h33, 1'b1, 1'b1);
    settle();
    check("flush_in_ready", int'(in_ready0), 0);
    check("flush_out_valid", int'(out_valid0), 0);
    edge_update();
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
    settle();
    check("flush_count", int'(count0), 0);
    check("flush_after_valid", int'(out_valid0), 0);
    edge_update();
    step();
    step();

    // Single-stage, single-bit instance: a valid-gated flip-flop.
    drive(1, 1'b1, 8'h01, 1'b0, 1'b0);
    settle();
    check("s1_in_ready_empty", int'(in_ready1), 1);
    edge_update();
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    settle();
    check("s1_out_valid", int'(out_valid1), 1);
    check("s1_out_data", int'(out_data1), 1);
    check("s1_in_ready_full", int'(in_ready1), 0);
    edge_update();
    drive(1, 1'b1, 8'h00, 1'b1, 1'b0);
    settle();
    check("s1_in_ready_pop", int'(in_ready1), 1);
    edge_update();
    drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
    settle();
    check("s1_next_valid", int'(out_valid1), 1);
    check("s1_next_data", int'(out_data1), 0);
    edge_update();

    random_cycles(800);

    // Asynchronous reset in the middle of a cycle with words in flight.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++) drive(i, 1'b1, 8'($urandom), 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 2; i++) drive(i, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    mq[0].delete();
    mq[1].delete();
    #1;
    check("arst_out_valid", int'(out_valid0), 0);
    check("arst_count", int'(count0), 0);
`ifdef DFF_PIPE_DATA_RST_EN
    check("arst_out_data", int'(out_data0), 8'hA5);
`endif
    settle();
    edge_update();
    rst_n = 1'b1;
    settle();
    check("arst_in_ready", int'(in_ready0), 1);
    edge_update();

    random_cycles(150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
